// File: rtl/clint_timer_pkg.sv
// Shared constants for the core-local interruptor: register offsets inside the
// CLINT window, bus FSM state encodings and the decode-hit bundle.
package clint_timer_pkg;

  localparam logic [63:0] CLINT_MSIP     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME    = 64'h0000_0000_0000_BFF8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  typedef struct packed {
    logic msip;
    logic mtimecmp;
    logic mtime;
  } clint_hit_t;

endpackage

// File: rtl/clint_timer_if.sv
// Data-bus slave port of the CLINT: request held by the master until the
// one-cycle resp_ready pulse; resp_data is valid only alongside it.
interface clint_timer_if;

  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_write;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_ready;
  logic [63:0] resp_data;

  modport master (
    output req_valid, req_addr, req_write, req_strobe, req_data,
    input  resp_ready, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_strobe, req_data,
    output resp_ready, resp_data
  );

endinterface

// File: rtl/clint_timer_sync2.sv
// Two-flop synchronizer for a single asynchronous level; output lags the input
// by two clock edges and both flops clear on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: owns mtime/mtimecmp/msip behind a small MMIO window and
// drives the raw trint/swint/exint levels; masking is left to the CSR unit.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  clint_timer_if.slave bus,
  input  logic         ext_irq,
  output logic         trint,
  output logic         swint,
  output logic         exint
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [63:0] MSIP_ADDR     = BASE + CLINT_MSIP;
  localparam logic [63:0] MTIMECMP_ADDR = BASE + CLINT_MTIMECMP;
  localparam logic [63:0] MTIME_ADDR    = BASE + CLINT_MTIME;

  function automatic logic [63:0] byte_merge(
    input logic [63:0] old_val,
    input logic [63:0] new_val,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          resp_ready_q, resp_ready_d;
  logic [63:0]   resp_data_q, resp_data_d;

  logic          tick;
  logic          accept;
  logic          wr_en;
  clint_hit_t    hit;
  logic [63:0]   rd_val;
  logic [63:0]   mtime_inc;
  logic          addr_lsb_unused;

  // Sub-word address bits never select anything: every register is 64-bit aligned.
  assign addr_lsb_unused = ^bus.req_addr[2:0];

  always_comb begin
    hit          = '0;
    hit.msip     = (bus.req_addr[63:3] == MSIP_ADDR[63:3]);
    hit.mtimecmp = (bus.req_addr[63:3] == MTIMECMP_ADDR[63:3]);
    hit.mtime    = (bus.req_addr[63:3] == MTIME_ADDR[63:3]);

    accept = (state_q == ST_IDLE) && bus.req_valid;
    wr_en  = accept && bus.req_write;

    rd_val = '0;
    if (hit.msip)          rd_val = {63'b0, msip_q};
    else if (hit.mtimecmp) rd_val = mtimecmp_q;
    else if (hit.mtime)    rd_val = mtime_q;
  end

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + PW'(1);
    mtime_inc = mtime_q + {63'b0, tick};

    // Unstrobed bytes of a same-cycle mtime write still see the tick.
    mtime_d = mtime_inc;
    if (wr_en && hit.mtime) begin
      mtime_d = byte_merge(mtime_inc, bus.req_data, bus.req_strobe);
    end

    mtimecmp_d = mtimecmp_q;
    if (wr_en && hit.mtimecmp) begin
      mtimecmp_d = byte_merge(mtimecmp_q, bus.req_data, bus.req_strobe);
    end

    msip_d = msip_q;
    if (wr_en && hit.msip && bus.req_strobe[0]) begin
      msip_d = bus.req_data[0];
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_ready_d = 1'b0;
    resp_data_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d      = ST_ACK;
          resp_ready_d = 1'b1;
          resp_data_d  = rd_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      resp_ready_q <= resp_ready_d;
      resp_data_q  <= resp_data_d;
    end
  end

  sync2 u_ext_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (ext_irq),
    .q     (exint)
  );

  assign bus.resp_ready = resp_ready_q;
  assign bus.resp_data  = resp_data_q;
  assign trint          = (mtime_q >= mtimecmp_q);
  assign swint          = msip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: one instance ticking every cycle, one with a
// divide-by-4 prescaler, sharing clock, reset and ext_irq.
module tb_clint_timer;
  import clint_timer_pkg::*;

  localparam logic [63:0] B = 64'h0200_0000;
  localparam logic [63:0] A_MSIP = B + CLINT_MSIP;
  localparam logic [63:0] A_CMP  = B + CLINT_MTIMECMP;
  localparam logic [63:0] A_TIME = B + CLINT_MTIME;
  localparam logic [63:0] A_MISS = B + 64'h1000;
  localparam logic [63:0] ALL1   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk;
  logic reset;
  logic ext_irq;
  logic trint1, swint1, exint1;
  logic trint4, swint4, exint4;

  clint_timer_if bus1 ();
  clint_timer_if bus4 ();

  clint_timer #(.BASE(B), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave), .ext_irq(ext_irq),
    .trint(trint1), .swint(swint1), .exint(exint1)
  );

  clint_timer #(.BASE(B), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .ext_irq(ext_irq),
    .trint(trint4), .swint(swint4), .exint(exint4)
  );

  int n_checks = 0;
  int n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d4, input logic vld, input bit wr, input logic [63:0] addr,
                       input logic [7:0] strb, input logic [63:0] data);
    if (d4) begin
      bus4.req_valid = vld; bus4.req_write = wr; bus4.req_addr = addr;
      bus4.req_strobe = strb; bus4.req_data = data;
    end else begin
      bus1.req_valid = vld; bus1.req_write = wr; bus1.req_addr = addr;
      bus1.req_strobe = strb; bus1.req_data = data;
    end
  endtask

  // Called at a negedge with the FSM idle; returns two negedges later, FSM idle again.
  task automatic do_req(input bit d4, input bit wr, input logic [63:0] addr,
                        input logic [7:0] strb, input logic [63:0] data,
                        output logic [63:0] rdata);
    logic seen;
    logic rr;
    seen  = 1'b0;
    rdata = '0;
    drive(d4, 1'b1, wr, addr, strb, data);
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      rr = d4 ? bus4.resp_ready : bus1.resp_ready;
      if (rr) begin
        seen  = 1'b1;
        rdata = d4 ? bus4.resp_data : bus1.resp_data;
      end
    end
    drive(d4, 1'b0, 1'b0, '0, '0, '0);
    check("resp_ready_seen", 64'(seen), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] rd;
    reset   = 1'b0;
    ext_irq = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

    @(negedge clk);
    check("rst_resp_ready", 64'(bus1.resp_ready), 64'd0);
    check("rst_resp_data", bus1.resp_data, 64'd0);
    check("rst_trint", 64'(trint1), 64'd0);
    check("rst_swint", 64'(swint1), 64'd0);
    check("rst_exint", 64'(exint1), 64'd0);
    reset = 1'b1;

    // Ten ticks with no traffic.
    repeat (10) @(negedge clk);
    check("idle_trint", 64'(trint1), 64'd0);
    do_req(1'b0, 1'b0, A_TIME, 8'h00, '0, rd);
    check("mtime_after_10", rd, 64'd10);

    // mtime is 12 here; compare fires when it reaches 20.
    do_req(1'b0, 1'b1, A_CMP, 8'hFF, 64'd20, rd);
    repeat (5) @(negedge clk);
    check("trint_at_19", 64'(trint1), 64'd0);
    @(negedge clk);
    check("trint_at_20", 64'(trint1), 64'd1);
    do_req(1'b0, 1'b1, A_CMP, 8'hFF, ALL1, rd);
    check("trint_cleared", 64'(trint1), 64'd0);

    do_req(1'b0, 1'b1, A_MSIP, 8'hFF, ALL1, rd);
    check("swint_set", 64'(swint1), 64'd1);
    do_req(1'b0, 1'b0, A_MSIP, 8'h00, '0, rd);
    check("msip_readback", rd, 64'd1);
    do_req(1'b0, 1'b1, A_MSIP, 8'hFF, 64'd0, rd);
    check("swint_clr", 64'(swint1), 64'd0);

    // Written value lands at acceptance, one more tick before return: mtime = all ones.
    do_req(1'b0, 1'b1, A_TIME, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, rd);
    check("trint_equal_max", 64'(trint1), 64'd1);
    @(negedge clk);
    check("trint_after_wrap", 64'(trint1), 64'd0);
    do_req(1'b0, 1'b0, A_TIME, 8'h00, '0, rd);
    check("mtime_wrapped", rd, 64'd0);

    // Old mtime 0x1FF ticks to 0x200, byte 0 replaced by 0xAA -> 0x2AA, then one tick.
    do_req(1'b0, 1'b1, A_TIME, 8'hFF, 64'h1FE, rd);
    do_req(1'b0, 1'b1, A_TIME, 8'h01, 64'h1122_3344_5566_77AA, rd);
    do_req(1'b0, 1'b0, A_TIME, 8'h00, '0, rd);
    check("mtime_strobe_tick", rd, 64'h2AB);

    // Held request: responses on every other cycle.
    drive(1'b0, 1'b1, 1'b0, A_CMP, 8'h00, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_ready", 64'(bus1.resp_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      check("b2b_data", bus1.resp_data, (i % 2 == 0) ? ALL1 : 64'd0);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);

    // Reset in the middle of an ACK.
    do_req(1'b0, 1'b1, A_CMP, 8'hFF, 64'd5, rd);
    do_req(1'b0, 1'b1, A_MSIP, 8'h01, 64'd1, rd);
    check("pre_rst_trint", 64'(trint1), 64'd1);
    check("pre_rst_swint", 64'(swint1), 64'd1);
    drive(1'b0, 1'b1, 1'b0, A_CMP, 8'h00, '0);
    @(negedge clk);
    check("ack_before_rst", 64'(bus1.resp_ready), 64'd1);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("midack_resp_ready", 64'(bus1.resp_ready), 64'd0);
    check("midack_resp_data", bus1.resp_data, 64'd0);
    check("midack_trint", 64'(trint1), 64'd0);
    check("midack_swint", 64'(swint1), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Divide-by-4: 12 edges after release give three ticks.
    repeat (12) @(negedge clk);
    do_req(1'b1, 1'b0, A_TIME, 8'h00, '0, rd);
    check("div4_mtime", rd, 64'd3);
    do_req(1'b0, 1'b0, A_CMP, 8'h00, '0, rd);
    check("post_rst_mtimecmp", rd, ALL1);
    do_req(1'b0, 1'b0, A_TIME, 8'h00, '0, rd);
    check("post_rst_mtime", rd, 64'd16);

    do_req(1'b1, 1'b0, A_MISS, 8'h00, '0, rd);
    check("miss_read", rd, 64'd0);
    do_req(1'b1, 1'b1, A_MISS, 8'hFF, ALL1, rd);
    do_req(1'b1, 1'b0, A_MSIP, 8'h00, '0, rd);
    check("miss_write_dropped", rd, 64'd0);
    check("miss_swint", 64'(swint4), 64'd0);

    // One-cycle ext_irq pulse through the synchronizer.
    ext_irq = 1'b1;
    @(negedge clk);
    ext_irq = 1'b0;
    check("exint_lag1", 64'(exint1), 64'd0);
    @(negedge clk);
    check("exint_lag2", 64'(exint1), 64'd1);
    check("exint4_lag2", 64'(exint4), 64'd1);
    @(negedge clk);
    check("exint_fall", 64'(exint1), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
